// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart_tx between 2**ID_W byte-stream requesters.
// Sequences the uart_tx_en / uart_tx_busy handshake one byte at a time.
module uart_tx_arbiter #(
    parameter int unsigned ID_W          = 2,
    parameter int unsigned MAX_BURST     = 16,
    parameter int unsigned START_TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [(1 << ID_W)-1:0]     req_valid,
    input  logic [(1 << ID_W)-1:0]     req_last,
    input  logic [(1 << ID_W)*8-1:0]   req_data,
    output logic [(1 << ID_W)-1:0]     req_ready,
    output logic                       grant_valid,
    output logic [ID_W-1:0]            grant_id,
    input  logic                       uart_tx_busy,
    output logic                       uart_tx_en,
    output logic [7:0]                 uart_tx_data
);

    localparam int unsigned NUM_REQ = 1 << ID_W;
    localparam int unsigned BEAT_W  = 8;
    localparam int unsigned START_W = 4;

    typedef enum logic [1:0] {IDLE, LOAD, START, DRAIN} state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [START_W-1:0]  start_cnt;
    logic                last_q;

    logic [ID_W-1:0]     winner_c;
    logic [7:0]          sel_data_c;
    logic                sel_last_c;
    logic                xfer_c;

    // First requesting index at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] idx;
        logic            found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ptr + ID_W'(k);
            if (!found && v[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign winner_c = rr_pick(req_valid, rr_ptr);

    always_comb begin
        sel_data_c = '0;
        sel_last_c = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                sel_data_c = req_data[8*k +: 8];
                sel_last_c = req_last[k];
            end
        end
    end

    // Only the grantee sees ready, and only while the transmitter is free.
    assign req_ready = (state == LOAD && !uart_tx_busy) ? (NUM_REQ'(1) << grant_id) : '0;
    assign xfer_c    = (state == LOAD) && !uart_tx_busy && req_valid[grant_id];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
            grant_valid  <= 1'b0;
            grant_id     <= '0;
            rr_ptr       <= '0;
            beat_cnt     <= '0;
            start_cnt    <= '0;
            last_q       <= 1'b0;
        end else begin
            uart_tx_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid && !uart_tx_busy) begin
                        grant_id    <= winner_c;
                        grant_valid <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (xfer_c) begin
                        uart_tx_data <= sel_data_c;
                        uart_tx_en   <= 1'b1;
                        last_q       <= sel_last_c;
                        beat_cnt     <= beat_cnt + BEAT_W'(1);
                        start_cnt    <= '0;
                        state        <= START;
                    end
                end
                START: begin
                    // A uart_tx that never raises busy must not wedge the arbiter.
                    if (uart_tx_busy) begin
                        state <= DRAIN;
                    end else if (start_cnt == START_W'(START_TIMEOUT - 1)) begin
                        state <= DRAIN;
                    end else begin
                        start_cnt <= start_cnt + START_W'(1);
                    end
                end
                DRAIN: begin
                    if (!uart_tx_busy) begin
                        if (last_q || beat_cnt == BEAT_W'(MAX_BURST)) begin
                            grant_valid <= 1'b0;
                            rr_ptr      <= grant_id + ID_W'(1);
                            beat_cnt    <= '0;
                            state       <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
